reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameters SHALL be: NUM_ENTRIES, default 32, number of ROB entries (power of two).
REQ-002 Parameters SHALL be: PHYREG_W, default 7, physical register id width.
REQ-003 Parameters SHALL be: ARCHREG_W, default 5, architectural register id width.
REQ-004 Ports SHALL be: SIG_CLK  in  1  single clock; all state updates on its rising edge.
REQ-005 Ports SHALL be: SIG_RSTn  in  1  reset, asynchronous, active-low.
REQ-006 Ports SHALL be: alloc_valid  in  1  rename stage presents one renamed instruction.
REQ-007 Ports SHALL be: alloc_ready  out  1  entry available for allocation.
REQ-008 Ports SHALL be: alloc_idx  out  log2(NUM_ENTRIES)  ROB index assigned to the presented instruction (tail).
REQ-009 Ports SHALL be: alloc_has_dst  in  1  instruction writes a destination register.
REQ-010 Ports SHALL be: alloc_arch_dst  in  ARCHREG_W  architectural destination.
REQ-011 Ports SHALL be: alloc_phy_dst  in  PHYREG_W  newly mapped physical destination.
REQ-012 Ports SHALL be: alloc_prev_phy  in  PHYREG_W  previously mapped physical register for alloc_arch_dst.
REQ-013 Ports SHALL be: wb_valid  in  1  execution completion report.
REQ-014 Ports SHALL be: wb_idx  in  log2(NUM_ENTRIES)  ROB index of the completed instruction.
REQ-015 Ports SHALL be: wb_exception  in  1  completed instruction raised an exception.
REQ-016 Ports SHALL be: commit_valid  out  1  one instruction retired this cycle (registered).
REQ-017 Ports SHALL be: commit_arch_dst / commit_phy_dst  out  ARCHREG_W / PHYREG_W  retired mapping for the architectural map table.
REQ-018 Ports SHALL be: free_valid  out  1  a physical register returns to the free list this cycle (registered).
REQ-019 Ports SHALL be: free_phy  out  PHYREG_W  physical register being freed (retired alloc_prev_phy).
REQ-020 Ports SHALL be: flush_valid  out  1  one-cycle pulse; exception at head, pipeline and rename state must recover.
REQ-021 Ports SHALL be: count  out  log2(NUM_ENTRIES)+1  occupied entries.

Function
REQ-022 Storage SHALL be a circular buffer; head/tail pointers carry one extra wrap bit; full = equal index, different wrap bit; empty = pointers equal.
REQ-023 Each entry SHALL hold valid, done, exception, has_dst, arch_dst, phy_dst, prev_phy.
REQ-024 alloc_ready SHALL be combinational: high iff count < NUM_ENTRIES and flush_valid low; no same-cycle bypass of a retiring slot.
REQ-025 alloc_idx SHALL equal the tail index combinationally.
REQ-026 On alloc_valid & alloc_ready at an edge, the tail entry SHALL be written with valid=1, done=0, exception=0, and the tail SHALL increment modulo 2*NUM_ENTRIES.
REQ-027 alloc_valid while alloc_ready is low SHALL be ignored with no state change.
REQ-028 On wb_valid at an edge, entry wb_idx SHALL set done=1 and exception=wb_exception if valid; a writeback to an invalid entry SHALL be ignored.
REQ-029 Retirement: at most one per cycle; at an edge where the head entry is valid, done, exception=0, outputs SHALL register commit_valid=1 with its arch/phy dst, the entry SHALL be invalidated, and the head SHALL increment.
REQ-030 On such retirement with has_dst=1, free_valid=1 and free_phy=prev_phy SHALL register on the same edge; with has_dst=0, free_valid=0 and commit_valid=1 still.
REQ-031 Minimum latency: writeback at edge M makes commit_valid visible after edge M+1.
REQ-032 Head entry valid, done, exception=1: at the next edge flush_valid SHALL pulse for one cycle, all entries invalidated, head=tail=0, count=0; commit_valid=free_valid=0 that cycle.
REQ-033 During the flush cycle, alloc and wb inputs SHALL be ignored.
REQ-034 Simultaneous allocation and retirement SHALL both take effect; count unchanged.
REQ-035 A writeback to the head entry on the edge it would otherwise be evaluated SHALL retire it no earlier than the following edge.
REQ-036 Pointer wrap from index NUM_ENTRIES-1 to 0 SHALL toggle the wrap bit and preserve full/empty detection.
REQ-037 commit_valid, free_valid, flush_valid SHALL each be high for exactly one cycle per event.

Reset
REQ-038 SIG_RSTn low SHALL asynchronously clear head, tail, count, all valid/done/exception bits, and all registered outputs (commit_valid, commit_arch_dst, commit_phy_dst, free_valid, free_phy, flush_valid) to 0.
REQ-039 After reset release, alloc_ready SHALL be 1 and alloc_idx 0.
REQ-040 Reset asserted mid-operation SHALL discard all in-flight entries without any commit or free pulse.

Verification
REQ-041 Reset, allocate idx0 (arch 5, phy 40, prev 5), wb idx0 -> commit_valid with arch 5, phy 40; free_valid, free_phy=5; count back to 0.
REQ-042 Allocate 32 without writeback -> count=32, alloc_ready=0; 33rd alloc ignored; wb idx0 -> alloc_ready=1 after retirement.
REQ-043 Allocate idx0..2, wb order 2,1,0 -> commits in order 0,1,2 on consecutive cycles after wb of idx0.
REQ-044 Allocate idx0..3, wb idx0 with exception -> flush_valid one cycle, no commit/free, count=0, next alloc_idx=0.
REQ-045 Steady stream over 70 allocations with immediate writeback -> wrap handled, no spurious full/empty, every prev_phy freed once.
REQ-046 Assert SIG_RSTn low asynchronously with 10 entries pending -> all outputs 0 immediately, count=0, no commit after release.

Source files
------------

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: entries are allocated at the tail by rename, marked done by
// writeback in any order, and retired one per cycle from the head; an excepting head flushes everything.
module reorder_buffer #(
    parameter int NUM_ENTRIES = 32,
    parameter int PHYREG_W    = 7,
    parameter int ARCHREG_W   = 5
) (
    input  logic                           SIG_CLK,
    input  logic                           SIG_RSTn,
    // Allocation handshake: an instruction is accepted at a rising edge only when
    // alloc_valid and alloc_ready are both high; alloc_valid alone has no effect.
    input  logic                           alloc_valid,
    output logic                           alloc_ready,
    output logic [$clog2(NUM_ENTRIES)-1:0] alloc_idx,
    input  logic                           alloc_has_dst,
    input  logic [ARCHREG_W-1:0]           alloc_arch_dst,
    input  logic [PHYREG_W-1:0]            alloc_phy_dst,
    input  logic [PHYREG_W-1:0]            alloc_prev_phy,
    input  logic                           wb_valid,
    input  logic [$clog2(NUM_ENTRIES)-1:0] wb_idx,
    input  logic                           wb_exception,
    output logic                           commit_valid,
    output logic [ARCHREG_W-1:0]           commit_arch_dst,
    output logic [PHYREG_W-1:0]            commit_phy_dst,
    output logic                           free_valid,
    output logic [PHYREG_W-1:0]            free_phy,
    output logic                           flush_valid,
    output logic [$clog2(NUM_ENTRIES):0]   count
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);

    logic [IDX_W:0]          head_q, head_d, tail_q, tail_d;
    logic [NUM_ENTRIES-1:0]  valid_q, valid_d, done_q, done_d, exc_q, exc_d;
    logic [NUM_ENTRIES-1:0]  has_dst_q;
    logic [ARCHREG_W-1:0]    arch_q [NUM_ENTRIES];
    logic [PHYREG_W-1:0]     phy_q  [NUM_ENTRIES];
    logic [PHYREG_W-1:0]     prev_q [NUM_ENTRIES];

    logic                    commit_valid_q, commit_valid_d;
    logic [ARCHREG_W-1:0]    commit_arch_q, commit_arch_d;
    logic [PHYREG_W-1:0]     commit_phy_q, commit_phy_d;
    logic                    free_valid_q, free_valid_d;
    logic [PHYREG_W-1:0]     free_phy_q, free_phy_d;
    logic                    flush_q, flush_d;

    logic [IDX_W-1:0] head_idx, tail_idx;
    logic full, head_ready, do_retire, do_flush, do_alloc, do_wb;

    assign head_idx = head_q[IDX_W-1:0];
    assign tail_idx = tail_q[IDX_W-1:0];
    // Same index with opposite wrap bits means the tail has lapped the head.
    assign full     = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);

    assign alloc_ready = !full && !flush_q;
    assign alloc_idx   = tail_idx;
    assign count       = tail_q - head_q;

    assign head_ready = valid_q[head_idx] && done_q[head_idx];
    assign do_retire  = head_ready && !exc_q[head_idx] && !flush_q;
    assign do_flush   = head_ready && exc_q[head_idx] && !flush_q;
    assign do_alloc   = alloc_valid && alloc_ready;
    assign do_wb      = wb_valid && !flush_q && valid_q[wb_idx];

    always_comb begin
        head_d         = head_q;
        tail_d         = tail_q;
        valid_d        = valid_q;
        done_d         = done_q;
        exc_d          = exc_q;
        commit_valid_d = 1'b0;
        commit_arch_d  = commit_arch_q;
        commit_phy_d   = commit_phy_q;
        free_valid_d   = 1'b0;
        free_phy_d     = free_phy_q;
        flush_d        = 1'b0;
        if (do_flush) begin
            valid_d = '0;
            done_d  = '0;
            exc_d   = '0;
            head_d  = '0;
            tail_d  = '0;
            flush_d = 1'b1;
        end else begin
            // Retirement looks only at registered done bits, so a writeback to the head
            // this edge retires it on the next edge at the earliest.
            if (do_wb) begin
                done_d[wb_idx] = 1'b1;
                exc_d[wb_idx]  = wb_exception;
            end
            if (do_retire) begin
                valid_d[head_idx] = 1'b0;
                done_d[head_idx]  = 1'b0;
                exc_d[head_idx]   = 1'b0;
                head_d            = head_q + 1'b1;
                commit_valid_d    = 1'b1;
                commit_arch_d     = arch_q[head_idx];
                commit_phy_d      = phy_q[head_idx];
                free_valid_d      = has_dst_q[head_idx];
                if (has_dst_q[head_idx]) begin
                    free_phy_d = prev_q[head_idx];
                end
            end
            if (do_alloc) begin
                valid_d[tail_idx] = 1'b1;
                done_d[tail_idx]  = 1'b0;
                exc_d[tail_idx]   = 1'b0;
                tail_d            = tail_q + 1'b1;
            end
        end
    end

    always_ff @(posedge SIG_CLK or negedge SIG_RSTn) begin
        if (!SIG_RSTn) begin
            head_q         <= '0;
            tail_q         <= '0;
            valid_q        <= '0;
            done_q         <= '0;
            exc_q          <= '0;
            commit_valid_q <= 1'b0;
            commit_arch_q  <= '0;
            commit_phy_q   <= '0;
            free_valid_q   <= 1'b0;
            free_phy_q     <= '0;
            flush_q        <= 1'b0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            valid_q        <= valid_d;
            done_q         <= done_d;
            exc_q          <= exc_d;
            commit_valid_q <= commit_valid_d;
            commit_arch_q  <= commit_arch_d;
            commit_phy_q   <= commit_phy_d;
            free_valid_q   <= free_valid_d;
            free_phy_q     <= free_phy_d;
            flush_q        <= flush_d;
        end
    end

    // Payload is qualified by the valid bit, so it needs no reset.
    always_ff @(posedge SIG_CLK) begin
        if (do_alloc) begin
            has_dst_q[tail_idx] <= alloc_has_dst;
            arch_q[tail_idx]    <= alloc_arch_dst;
            phy_q[tail_idx]     <= alloc_phy_dst;
            prev_q[tail_idx]    <= alloc_prev_phy;
        end
    end

    assign commit_valid    = commit_valid_q;
    assign commit_arch_dst = commit_arch_q;
    assign commit_phy_dst  = commit_phy_q;
    assign free_valid      = free_valid_q;
    assign free_phy        = free_phy_q;
    assign flush_valid     = flush_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: each task drives one scenario and checks its
// outputs against hand-computed values.
module tb_reorder_buffer;

    logic       SIG_CLK;
    logic       SIG_RSTn;
    logic       alloc_valid;
    logic       alloc_ready;
    logic [4:0] alloc_idx;
    logic       alloc_has_dst;
    logic [4:0] alloc_arch_dst;
    logic [6:0] alloc_phy_dst;
    logic [6:0] alloc_prev_phy;
    logic       wb_valid;
    logic [4:0] wb_idx;
    logic       wb_exception;
    logic       commit_valid;
    logic [4:0] commit_arch_dst;
    logic [6:0] commit_phy_dst;
    logic       free_valid;
    logic [6:0] free_phy;
    logic       flush_valid;
    logic [5:0] count;

    int n_cmp = 0;
    int n_err = 0;

    logic [6:0] exp_q[$];
    logic [6:0] exp_phy_q[$];

    reorder_buffer #(.NUM_ENTRIES(32), .PHYREG_W(7), .ARCHREG_W(5)) dut (
        .SIG_CLK(SIG_CLK),
        .SIG_RSTn(SIG_RSTn),
        .alloc_valid(alloc_valid),
        .alloc_ready(alloc_ready),
        .alloc_idx(alloc_idx),
        .alloc_has_dst(alloc_has_dst),
        .alloc_arch_dst(alloc_arch_dst),
        .alloc_phy_dst(alloc_phy_dst),
        .alloc_prev_phy(alloc_prev_phy),
        .wb_valid(wb_valid),
        .wb_idx(wb_idx),
        .wb_exception(wb_exception),
        .commit_valid(commit_valid),
        .commit_arch_dst(commit_arch_dst),
        .commit_phy_dst(commit_phy_dst),
        .free_valid(free_valid),
        .free_phy(free_phy),
        .flush_valid(flush_valid),
        .count(count)
    );

    initial SIG_CLK = 1'b0;
    always #5 SIG_CLK = ~SIG_CLK;

    task automatic tick;
        @(posedge SIG_CLK);
        #1;
    endtask

    task automatic apply_reset;
        SIG_RSTn       = 1'b0;
        alloc_valid    = 1'b0;
        alloc_has_dst  = 1'b0;
        alloc_arch_dst = '0;
        alloc_phy_dst  = '0;
        alloc_prev_phy = '0;
        wb_valid       = 1'b0;
        wb_idx         = '0;
        wb_exception   = 1'b0;
        repeat (2) @(posedge SIG_CLK);
        #1;
        SIG_RSTn = 1'b1;
        tick();
    endtask

    task automatic alloc_entry(input logic has_dst, input logic [4:0] arch,
                               input logic [6:0] phy, input logic [6:0] prev);
        alloc_valid    = 1'b1;
        alloc_has_dst  = has_dst;
        alloc_arch_dst = arch;
        alloc_phy_dst  = phy;
        alloc_prev_phy = prev;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic writeback(input logic [4:0] idx, input logic exc);
        wb_valid     = 1'b1;
        wb_idx       = idx;
        wb_exception = exc;
        tick();
        wb_valid     = 1'b0;
        wb_exception = 1'b0;
    endtask

    task automatic test_reset;
        apply_reset();
        n_cmp++; if (count !== 6'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", alloc_ready); end
        n_cmp++; if (alloc_idx !== 5'd0) begin n_err++; $display("FAIL reset_idx: got %0d want 0", alloc_idx); end
        n_cmp++; if ({commit_valid, free_valid, flush_valid} !== 3'b000) begin
            n_err++; $display("FAIL reset_pulses: got %b want 000", {commit_valid, free_valid, flush_valid});
        end
        n_cmp++; if ({commit_arch_dst, commit_phy_dst, free_phy} !== 19'd0) begin
            n_err++; $display("FAIL reset_data: got %h want 0", {commit_arch_dst, commit_phy_dst, free_phy});
        end
    endtask

    task automatic test_single;
        apply_reset();
        alloc_entry(1'b1, 5'd5, 7'd40, 7'd5);
        n_cmp++; if (count !== 6'd1) begin n_err++; $display("FAIL single_count1: got %0d want 1", count); end
        n_cmp++; if (alloc_idx !== 5'd1) begin n_err++; $display("FAIL single_idx: got %0d want 1", alloc_idx); end
        writeback(5'd0, 1'b0);
        n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL single_early_commit: got %b want 0", commit_valid); end
        tick();
        n_cmp++; if (commit_valid !== 1'b1) begin n_err++; $display("FAIL single_commit: got %b want 1", commit_valid); end
        n_cmp++; if (commit_arch_dst !== 5'd5) begin n_err++; $display("FAIL single_arch: got %0d want 5", commit_arch_dst); end
        n_cmp++; if (commit_phy_dst !== 7'd40) begin n_err++; $display("FAIL single_phy: got %0d want 40", commit_phy_dst); end
        n_cmp++; if (free_valid !== 1'b1) begin n_err++; $display("FAIL single_free: got %b want 1", free_valid); end
        n_cmp++; if (free_phy !== 7'd5) begin n_err++; $display("FAIL single_free_phy: got %0d want 5", free_phy); end
        n_cmp++; if (count !== 6'd0) begin n_err++; $display("FAIL single_count0: got %0d want 0", count); end
        tick();
        n_cmp++; if ({commit_valid, free_valid} !== 2'b00) begin
            n_err++; $display("FAIL single_pulse_width: got %b want 00", {commit_valid, free_valid});
        end
    endtask

    task automatic test_full;
        apply_reset();
        for (int i = 0; i < 32; i++) begin
            alloc_entry(1'b1, 5'(i), 7'(i + 10), 7'(i + 50));
        end
        n_cmp++; if (count !== 6'd32) begin n_err++; $display("FAIL full_count: got %0d want 32", count); end
        n_cmp++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", alloc_ready); end
        n_cmp++; if (alloc_idx !== 5'd0) begin n_err++; $display("FAIL full_idx: got %0d want 0", alloc_idx); end
        alloc_entry(1'b1, 5'd31, 7'd127, 7'd127);
        n_cmp++; if (count !== 6'd32) begin n_err++; $display("FAIL full_overflow: got %0d want 32", count); end
        writeback(5'd0, 1'b0);
        n_cmp++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL full_ready_pre: got %b want 0", alloc_ready); end
        tick();
        n_cmp++; if (commit_valid !== 1'b1) begin n_err++; $display("FAIL full_commit: got %b want 1", commit_valid); end
        n_cmp++; if ({commit_arch_dst, commit_phy_dst, free_phy} !== {5'd0, 7'd10, 7'd50}) begin
            n_err++; $display("FAIL full_commit_data: got %h want %h", {commit_arch_dst, commit_phy_dst, free_phy}, {5'd0, 7'd10, 7'd50});
        end
        n_cmp++; if (count !== 6'd31) begin n_err++; $display("FAIL full_count_after: got %0d want 31", count); end
        n_cmp++; if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_after: got %b want 1", alloc_ready); end
    endtask

    task automatic test_out_of_order;
        apply_reset();
        alloc_entry(1'b1, 5'd1, 7'd20, 7'd30);
        alloc_entry(1'b0, 5'd2, 7'd21, 7'd31);
        alloc_entry(1'b1, 5'd3, 7'd22, 7'd32);
        writeback(5'd2, 1'b0);
        writeback(5'd1, 1'b0);
        n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL ooo_no_commit: got %b want 0", commit_valid); end
        writeback(5'd0, 1'b0);
        n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL ooo_latency: got %b want 0", commit_valid); end
        tick();
        n_cmp++; if ({commit_valid, commit_arch_dst, commit_phy_dst, free_valid, free_phy} !== {1'b1, 5'd1, 7'd20, 1'b1, 7'd30}) begin
            n_err++; $display("FAIL ooo_commit0: got %h want %h", {commit_valid, commit_arch_dst, commit_phy_dst, free_valid, free_phy}, {1'b1, 5'd1, 7'd20, 1'b1, 7'd30});
        end
        tick();
        n_cmp++; if ({commit_valid, commit_arch_dst, commit_phy_dst, free_valid} !== {1'b1, 5'd2, 7'd21, 1'b0}) begin
            n_err++; $display("FAIL ooo_commit1: got %h want %h", {commit_valid, commit_arch_dst, commit_phy_dst, free_valid}, {1'b1, 5'd2, 7'd21, 1'b0});
        end
        tick();
        n_cmp++; if ({commit_valid, commit_arch_dst, commit_phy_dst, free_valid, free_phy} !== {1'b1, 5'd3, 7'd22, 1'b1, 7'd32}) begin
            n_err++; $display("FAIL ooo_commit2: got %h want %h", {commit_valid, commit_arch_dst, commit_phy_dst, free_valid, free_phy}, {1'b1, 5'd3, 7'd22, 1'b1, 7'd32});
        end
        n_cmp++; if (count !== 6'd0) begin n_err++; $display("FAIL ooo_count: got %0d want 0", count); end
        tick();
        n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL ooo_idle: got %b want 0", commit_valid); end
    endtask

    task automatic test_exception;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            alloc_entry(1'b1, 5'(i), 7'(i + 60), 7'(i + 70));
        end
        writeback(5'd1, 1'b0);
        writeback(5'd0, 1'b1);
        alloc_valid = 1'b1;
        tick();
        n_cmp++; if (flush_valid !== 1'b1) begin n_err++; $display("FAIL exc_flush: got %b want 1", flush_valid); end
        n_cmp++; if ({commit_valid, free_valid} !== 2'b00) begin
            n_err++; $display("FAIL exc_no_commit: got %b want 00", {commit_valid, free_valid});
        end
        n_cmp++; if (count !== 6'd0) begin n_err++; $display("FAIL exc_count: got %0d want 0", count); end
        n_cmp++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL exc_ready_flush: got %b want 0", alloc_ready); end
        wb_valid = 1'b1;
        wb_idx   = 5'd0;
        tick();
        alloc_valid = 1'b0;
        wb_valid    = 1'b0;
        n_cmp++; if (flush_valid !== 1'b0) begin n_err++; $display("FAIL exc_flush_width: got %b want 0", flush_valid); end
        n_cmp++; if (count !== 6'd0) begin n_err++; $display("FAIL exc_alloc_ignored: got %0d want 0", count); end
        n_cmp++; if (alloc_idx !== 5'd0) begin n_err++; $display("FAIL exc_next_idx: got %0d want 0", alloc_idx); end
        n_cmp++; if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL exc_ready_after: got %b want 1", alloc_ready); end
    endtask

    task automatic test_back_to_back;
        int frees;
        apply_reset();
        exp_q.delete();
        exp_phy_q.delete();
        frees = 0;
        for (int k = 0; k < 74; k++) begin
            if (k < 70) begin
                alloc_valid    = 1'b1;
                alloc_has_dst  = 1'b1;
                alloc_arch_dst = 5'(k % 32);
                alloc_phy_dst  = 7'(k + 50);
                alloc_prev_phy = 7'(k);
                exp_q.push_back(7'(k));
                exp_phy_q.push_back(7'(k + 50));
                n_cmp++; if (alloc_idx !== 5'(k % 32)) begin n_err++; $display("FAIL stream_idx k=%0d: got %0d want %0d", k, alloc_idx, k % 32); end
                n_cmp++; if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready k=%0d: got %b want 1", k, alloc_ready); end
            end else begin
                alloc_valid = 1'b0;
            end
            wb_valid     = (k >= 1 && k <= 70);
            wb_idx       = 5'((k + 31) % 32);
            wb_exception = 1'b0;
            tick();
            n_cmp++; if (free_valid !== commit_valid) begin
                n_err++; $display("FAIL stream_pair k=%0d: free %b commit %b", k, free_valid, commit_valid);
            end
            if (commit_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL stream_spurious k=%0d: got commit want none", k);
                end else begin
                    if (free_phy !== exp_q[0] || commit_phy_dst !== exp_phy_q[0]) begin
                        n_err++; $display("FAIL stream_data k=%0d: got %0d/%0d want %0d/%0d", k, free_phy, commit_phy_dst, exp_q[0], exp_phy_q[0]);
                    end
                    void'(exp_q.pop_front());
                    void'(exp_phy_q.pop_front());
                    frees++;
                end
            end
        end
        wb_valid = 1'b0;
        n_cmp++; if (frees !== 70) begin n_err++; $display("FAIL stream_frees: got %0d want 70", frees); end
        n_cmp++; if (count !== 6'd0) begin n_err++; $display("FAIL stream_count: got %0d want 0", count); end
    endtask

    task automatic test_reset_mid;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            alloc_entry(1'b1, 5'(i), 7'(i + 80), 7'(i + 90));
        end
        writeback(5'd0, 1'b0);
        writeback(5'd1, 1'b0);
        n_cmp++; if (commit_valid !== 1'b1) begin n_err++; $display("FAIL mid_commit_before: got %b want 1", commit_valid); end
        #2;
        SIG_RSTn = 1'b0;
        #1;
        n_cmp++; if ({commit_valid, free_valid, flush_valid} !== 3'b000) begin
            n_err++; $display("FAIL mid_pulses: got %b want 000", {commit_valid, free_valid, flush_valid});
        end
        n_cmp++; if ({commit_arch_dst, commit_phy_dst, free_phy} !== 19'd0) begin
            n_err++; $display("FAIL mid_data: got %h want 0", {commit_arch_dst, commit_phy_dst, free_phy});
        end
        n_cmp++; if (count !== 6'd0) begin n_err++; $display("FAIL mid_count: got %0d want 0", count); end
        tick();
        SIG_RSTn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if ({commit_valid, free_valid} !== 2'b00 || count !== 6'd0) begin
                n_err++; $display("FAIL mid_after_release cyc=%0d: got %b cnt %0d want 00 cnt 0", i, {commit_valid, free_valid}, count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_out_of_order();
        test_exception();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
